// File: rtl/tilt_classifier.sv
// Tilt classifier: turns raw unsigned X/Y accelerometer samples into a
// debounced, hysteresis-filtered 4-bit tilt direction vector with a
// one-cycle change strobe.
//
// Per-axis committed state
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_NEUTRAL | axis level, both tilt bits of the axis clear
//   ST_POS     | axis tilted positive (Y: left,  X: forward)
//   ST_NEG     | axis tilted negative (Y: right, X: back)
//
// Axis index 0 is Y, index 1 is X, matching the tilt bit packing
// {X NEG, X POS, Y NEG, Y POS}.
module tilt_classifier #(
    parameter int                DATA_W    = 9,
    parameter logic [DATA_W-1:0] HI_THRESH = 9'h1A0,
    parameter logic [DATA_W-1:0] LO_THRESH = 9'h0A0,
    parameter logic [DATA_W-1:0] HYST      = 9'h010,
    parameter int                DEBOUNCE  = 4,
    parameter int                CNT_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] accelX,
    input  logic [DATA_W-1:0] accelY,
    output logic [3:0]        tilt,
    output logic              tilt_changed
);

    typedef enum logic [1:0] {
        ST_NEUTRAL = 2'd0,
        ST_POS     = 2'd1,
        ST_NEG     = 2'd2
    } axis_state_t;

    // Relaxed thresholds used only while an axis is already committed.
    localparam logic [DATA_W-1:0] HI_HOLD  = HI_THRESH - HYST;
    localparam logic [DATA_W-1:0] LO_HOLD  = LO_THRESH + HYST;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DEB_CNT  = CNT_W'(DEBOUNCE);

    axis_state_t       r_state [2];
    axis_state_t       r_prev  [2];
    logic [CNT_W-1:0]  r_cnt   [2];
    logic [3:0]        r_tilt;
    logic              r_tilt_changed;

    logic [DATA_W-1:0] w_sample    [2];
    axis_state_t       w_cand      [2];
    logic [CNT_W-1:0]  w_cnt_inc   [2];
    logic              w_commit    [2];
    axis_state_t       w_state_nxt [2];

    // Candidate state for one sample, given the axis' committed state.
    function automatic axis_state_t classify(axis_state_t committed,
                                             logic [DATA_W-1:0] s);
        axis_state_t c;
        case (committed)
            ST_POS: begin
                if (s >= HI_HOLD)        c = ST_POS;
                else if (s <= LO_THRESH) c = ST_NEG;
                else                     c = ST_NEUTRAL;
            end
            ST_NEG: begin
                if (s <= LO_HOLD)        c = ST_NEG;
                else if (s >= HI_THRESH) c = ST_POS;
                else                     c = ST_NEUTRAL;
            end
            default: begin
                if (s >= HI_THRESH)      c = ST_POS;
                else if (s <= LO_THRESH) c = ST_NEG;
                else                     c = ST_NEUTRAL;
            end
        endcase
        return c;
    endfunction

    assign w_sample[0] = accelY;
    assign w_sample[1] = accelX;

    // Classify, advance the run length and decide whether this sample commits.
    always_comb begin
        for (int a = 0; a < 2; a++) begin
            w_cand[a]      = classify(r_state[a], w_sample[a]);
            w_cnt_inc[a]   = (w_cand[a] == r_prev[a]) ? (r_cnt[a] + CNT_ONE) : CNT_ONE;
            w_commit[a]    = sample_valid && (w_cand[a] != r_state[a]) &&
                             (w_cnt_inc[a] == DEB_CNT);
            w_state_nxt[a] = w_commit[a] ? w_cand[a] : r_state[a];
        end
    end

    // Axis FSMs, debounce counters and registered tilt outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int a = 0; a < 2; a++) begin
                r_state[a] <= ST_NEUTRAL;
                r_prev[a]  <= ST_NEUTRAL;
                r_cnt[a]   <= '0;
            end
            r_tilt         <= 4'b0000;
            r_tilt_changed <= 1'b0;
        end else begin
            if (sample_valid) begin
                for (int a = 0; a < 2; a++) begin
                    r_prev[a]  <= w_cand[a];
                    r_state[a] <= w_state_nxt[a];
                    if ((w_cand[a] == r_state[a]) || w_commit[a])
                        r_cnt[a] <= '0;
                    else
                        r_cnt[a] <= w_cnt_inc[a];
                end
            end
            r_tilt <= {w_state_nxt[1] == ST_NEG, w_state_nxt[1] == ST_POS,
                       w_state_nxt[0] == ST_NEG, w_state_nxt[0] == ST_POS};
            // Every commit changes its axis, so any commit changes tilt;
            // simultaneous commits on both axes merge into one pulse.
            r_tilt_changed <= w_commit[0] | w_commit[1];
        end
    end

    assign tilt         = r_tilt;
    assign tilt_changed = r_tilt_changed;

endmodule

// File: tb/tb_tilt_classifier.sv
// Directed bench for tilt_classifier: a table of per-cycle vectors with
// hand-computed tilt/tilt_changed, followed by an asynchronous reset sequence.
module tb_tilt_classifier;

    logic       clk;
    logic       reset;
    logic       sample_valid;
    logic [8:0] accelX;
    logic [8:0] accelY;
    logic [3:0] tilt;
    logic       tilt_changed;

    int n_vec;
    int n_err;

    typedef struct {
        logic       v;
        logic [8:0] x;
        logic [8:0] y;
        logic [3:0] t;
        logic       c;
    } vec_t;

    vec_t vecs[$];

    tilt_classifier dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .accelX       (accelX),
        .accelY       (accelY),
        .tilt         (tilt),
        .tilt_changed (tilt_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic v, input logic [8:0] x, input logic [8:0] y,
                       input logic [3:0] t, input logic c);
        vec_t e;
        e.v = v; e.x = x; e.y = y; e.t = t; e.c = c;
        vecs.push_back(e);
    endtask

    // n valid samples with tilt held at t throughout
    task automatic add_hold(input int n, input logic [8:0] x, input logic [8:0] y,
                            input logic [3:0] t);
        for (int i = 0; i < n; i++) add(1'b1, x, y, t, 1'b0);
    endtask

    // n valid samples where the last one commits: tilt goes t0 -> t1 with a pulse
    task automatic add_commit(input int n, input logic [8:0] x, input logic [8:0] y,
                              input logic [3:0] t0, input logic [3:0] t1);
        for (int i = 0; i < n - 1; i++) add(1'b1, x, y, t0, 1'b0);
        add(1'b1, x, y, t1, 1'b1);
    endtask

    task automatic check(input string name, input logic [3:0] exp_t, input logic exp_c);
        n_vec++;
        if (tilt !== exp_t || tilt_changed !== exp_c) begin
            n_err++;
            $display("FAIL %s: tilt=%b tilt_changed=%b, required tilt=%b tilt_changed=%b",
                     name, tilt, tilt_changed, exp_t, exp_c);
        end
    endtask

    task automatic step(input logic v, input logic [8:0] x, input logic [8:0] y);
        @(negedge clk);
        sample_valid = v;
        accelX       = x;
        accelY       = y;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        sample_valid = 1'b0;
        accelX = 9'h100;
        accelY = 9'h100;

        // Y debounce: 3 hits then a neutral sample aborts, then 4 hits commit
        add_hold(3, 9'h100, 9'h1B0, 4'b0000);
        add_hold(1, 9'h100, 9'h100, 4'b0000);
        add_commit(4, 9'h100, 9'h1B0, 4'b0000, 4'b0001);
        add(1'b0, 9'h100, 9'h1B0, 4'b0001, 1'b0);
        // Hysteresis: 0x195 holds POS, 0x18F releases to NEUTRAL
        add_hold(10, 9'h100, 9'h195, 4'b0001);
        add_commit(4, 9'h100, 9'h18F, 4'b0001, 4'b0000);
        // Direct POS -> NEG swing on Y
        add_commit(4, 9'h100, 9'h1B0, 4'b0000, 4'b0001);
        add_commit(4, 9'h100, 9'h050, 4'b0001, 4'b0010);
        // Back to neutral, then simultaneous X forward / Y right
        add_commit(4, 9'h100, 9'h100, 4'b0010, 4'b0000);
        add_commit(4, 9'h1C0, 9'h080, 4'b0000, 4'b0110);
        add(1'b0, 9'h1C0, 9'h080, 4'b0110, 1'b0);
        add_commit(4, 9'h100, 9'h100, 4'b0110, 4'b0000);
        // Just inside the neutral band on both thresholds: no commit
        add_hold(4, 9'h19F, 9'h0A1, 4'b0000);
        // X exactly at HI threshold on valid samples separated by idle cycles
        for (int i = 0; i < 3; i++) begin
            add(1'b1, 9'h1A0, 9'h100, 4'b0000, 1'b0);
            add(1'b0, 9'h1A0, 9'h100, 4'b0000, 1'b0);
        end
        add(1'b1, 9'h1A0, 9'h100, 4'b0100, 1'b1);
        add(1'b0, 9'h1A0, 9'h100, 4'b0100, 1'b0);
        // X exactly at LO threshold: direct swing to back
        add_commit(4, 9'h0A0, 9'h100, 4'b0100, 4'b1000);
        // NEG hysteresis edge: 0xB0 holds, 0xB1 releases
        add_hold(4, 9'h0B0, 9'h100, 4'b1000);
        add_commit(4, 9'h0B1, 9'h100, 4'b1000, 4'b0000);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 4'b0000, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].x, vecs[i].y);
            check($sformatf("vec%0d", i), vecs[i].t, vecs[i].c);
        end

        // Async reset mid-debounce with X committed forward
        step(1'b1, 9'h1C0, 9'h100);
        step(1'b1, 9'h1C0, 9'h100);
        step(1'b1, 9'h1C0, 9'h100);
        step(1'b1, 9'h1C0, 9'h100);
        check("rst_pre_commit", 4'b0100, 1'b1);
        step(1'b1, 9'h050, 9'h100);
        step(1'b1, 9'h050, 9'h100);
        check("rst_mid_debounce", 4'b0100, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("rst_async", 4'b0000, 1'b0);
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 9'h050, 9'h100);
            check($sformatf("rst_recommit%0d", i), 4'b0000, 1'b0);
        end
        step(1'b1, 9'h050, 9'h100);
        check("rst_recommit3", 4'b1000, 1'b1);
        step(1'b0, 9'h050, 9'h100);
        check("rst_pulse_end", 4'b1000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
